anemo_wind_averager: RTL and testbench
======================================

Name: anemo_wind_averager

Overview:
- Downstream consumer of the anemometer measurement stage.
- Takes each 8-bit wind-speed sample together with its one-cycle data-valid strobe.
- Produces a moving average over 2^LOG2_DEPTH samples, a hysteresis wind alarm and a primed flag.
- Outputs feed the LED/PWM logic and a software-readable PIO.

Parameters:
- LOG2_DEPTH, 3: window = 2^LOG2_DEPTH samples; legal range 1..6.
- ALARM_ON, 200: alarm sets when the new average is >= this value.
- ALARM_OFF, 180: alarm clears when the new average is < this value. Must be <= ALARM_ON; this is an elaboration-time check.

Ports:
- clk_clk  in  1  system clock.
- reset_reset  in  1  synchronous, active-high reset.
- clear  in  1  synchronous soft clear; same effect as reset.
- data_in  in  8  wind-speed sample.
- data_valid  in  1  one-cycle strobe; data_in is sampled while it is high.
- avg_out  out  8  moving average.
- avg_valid  out  1  one-cycle pulse when avg_out updates.
- avg_primed  out  1  high once the window has been completely filled.
- alarm  out  1  hysteresis wind alarm.
- peak_out  out  8  peak sample; see Optional Feature.

Behaviour:
- Single clock domain: one clock (clk_clk); reset_reset is synchronous and active-high.
- Reset and clear act on the same rising edge:
  - circular buffer entries = 0, sum = 0, write pointer = 0, fill counter = 0;
  - avg_out = 0, avg_valid = 0, avg_primed = 0, alarm = 0, peak_out = 0.
- Priority: reset_reset > clear > data_valid. A sample arriving in a clear cycle is dropped.
- Sum register: width 8+LOG2_DEPTH, unsigned; it cannot overflow. Fill counter: width LOG2_DEPTH+1, saturates at 2^LOG2_DEPTH.
- Edge E0, the edge at which data_valid=1:
  - sum <= sum + data_in - buf[wptr];
  - buf[wptr] <= data_in;
  - wptr <= wptr+1, wrapping modulo depth;
  - fill counter increments unless saturated.
- Edge E1:
  - avg_out <= sum >> LOG2_DEPTH, truncating;
  - avg_valid <= 1 for exactly one cycle;
  - avg_primed <= (fill == depth), sticky until reset or clear.
- Alarm, evaluated only at E1 on the new average A:
  - if A >= ALARM_ON, alarm <= 1;
  - else if A < ALARM_OFF, alarm <= 0;
  - otherwise alarm holds.
- Latency: avg_valid is high during the cycle after E1, i.e. 2 clocks after the data_valid cycle.
- Back-to-back data_valid on every cycle is fully supported: one avg_valid pulse per sample, in order, with no stall.
- No backpressure.
- During fill, empty entries count as zero, so the average ramps up. avg_primed tells software when it is meaningful.
- Reset or clear asserted between E0 and E1 cancels the pending avg_valid pulse.

Optional Feature:
- Macro: ANEMO_PEAK_HOLD_EN.
- Defined:
  - peak_out tracks the maximum raw data_in accepted since reset or clear, updated at E0;
  - a sample equal to the current peak leaves it unchanged.
- Undefined:
  - peak_out is constant 0;
  - no peak register is synthesised.

Decomposition:
- Package anemo_pkg:
  - SAMPLE_W = 8;
  - sample_t typedef;
  - function to compute sum width from LOG2_DEPTH;
  - default ALARM_ON / ALARM_OFF constants.
- One natural sub-module: anemo_hyst_cmp, the registered hysteresis comparator.
  - Inputs: value, update strobe, ON/OFF thresholds.
  - Output: alarm.

Test Plan:
- Bench uses LOG2_DEPTH=2, ALARM_ON=200, ALARM_OFF=180.
- Reset, then 100 x4 back-to-back -> avg_out 25, 50, 75, 100 on four consecutive avg_valid pulses; avg_primed rises with the fourth; alarm=0.
- Continue with 200 x4 -> avg 125, 150, 175, 200; alarm rises with the 200 pulse only.
- Continue with 160 x3 -> avg 190 (alarm=1), 180 (alarm=1, not < OFF), 170 (alarm=0).
- Samples spaced 5 cycles apart -> each avg_valid is exactly 2 clocks after its data_valid and is 1 cycle wide.
- clear asserted in the same cycle as data_valid=255 -> sample ignored; all outputs 0; the next sample 40 gives avg 10 and avg_primed=0.
- With ANEMO_PEAK_HOLD_EN: feed 30, 90, 50 -> peak_out 30, 90, 90; after clear it is 0. Without the macro, peak_out stays 0 throughout.

Source files
------------

// File: rtl/anemo_pkg.sv
// Shared types and constants for the wind-speed averaging block.
package anemo_pkg;

  localparam int SAMPLE_W = 8;

  typedef logic [SAMPLE_W-1:0] sample_t;

  // Default alarm thresholds on the averaged wind speed.
  localparam int ALARM_ON_DEF  = 200;
  localparam int ALARM_OFF_DEF = 180;

  // Running-sum width: a full window of maximum samples never overflows it.
  function automatic int sum_width(input int log2_depth);
    return SAMPLE_W + log2_depth;
  endfunction

endpackage

// File: rtl/anemo_hyst_cmp.sv
// Registered hysteresis comparator: sets at or above the ON threshold,
// clears strictly below the OFF threshold, holds in between. Only moves
// when i_update is high.
module anemo_hyst_cmp
  import anemo_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_update,
  input  logic [SAMPLE_W-1:0] i_value,
  input  logic [SAMPLE_W-1:0] i_on,
  input  logic [SAMPLE_W-1:0] i_off,
  output logic                o_alarm
);

  logic r_alarm;

  // Alarm state: synchronous clear, evaluated only on update strobes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_alarm <= 1'b0;
    end else if (i_update) begin
      if (i_value >= i_on) begin
        r_alarm <= 1'b1;
      end else if (i_value < i_off) begin
        r_alarm <= 1'b0;
      end
    end
  end

  assign o_alarm = r_alarm;

endmodule

// File: rtl/anemo_wind_averager.sv
// Moving average of wind-speed samples over 2^LOG2_DEPTH entries, with a
// hysteresis alarm on the average and a primed flag once the window is full.
// Optional peak hold of raw samples is enabled by defining ANEMO_PEAK_HOLD_EN;
// without it peak_out is tied to zero.
//
// Pipeline: the sample edge (E0) updates the window and running sum; the
// following edge (E1) publishes the average, so avg_valid appears two clocks
// after the data_valid cycle. A new sample may arrive every cycle.
module anemo_wind_averager
  import anemo_pkg::*;
#(
  parameter int LOG2_DEPTH = 3,
  parameter int ALARM_ON   = ALARM_ON_DEF,
  parameter int ALARM_OFF  = ALARM_OFF_DEF
)
(
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic                clear,
  input  logic [SAMPLE_W-1:0] data_in,
  input  logic                data_valid,
  output logic [SAMPLE_W-1:0] avg_out,
  output logic                avg_valid,
  output logic                avg_primed,
  output logic                alarm,
  output logic [SAMPLE_W-1:0] peak_out
);

  localparam int                  DEPTH     = 1 << LOG2_DEPTH;
  localparam int                  SUM_W     = sum_width(LOG2_DEPTH);
  localparam logic [LOG2_DEPTH:0] FILL_FULL = (LOG2_DEPTH + 1)'(DEPTH);

  generate
    if (LOG2_DEPTH < 1 || LOG2_DEPTH > 6) begin : g_bad_depth
      $error("anemo_wind_averager: LOG2_DEPTH must be within 1..6");
    end
    if (ALARM_OFF > ALARM_ON) begin : g_bad_thresh
      $error("anemo_wind_averager: ALARM_OFF must not exceed ALARM_ON");
    end
    if (ALARM_ON < 0 || ALARM_ON > 255 || ALARM_OFF < 0) begin : g_bad_range
      $error("anemo_wind_averager: alarm thresholds must fit an 8-bit sample");
    end
  endgenerate

  sample_t                r_buf [DEPTH];
  logic [SUM_W-1:0]       r_sum;
  logic [LOG2_DEPTH-1:0]  r_wptr;
  logic [LOG2_DEPTH:0]    r_fill;
  logic                   r_pend;
  sample_t                r_avg;
  logic                   r_avg_valid;
  logic                   r_primed;

  logic                   w_clr;
  logic                   w_accept;
  sample_t                w_old;
  logic [SUM_W-1:0]       w_sum_next;
  sample_t                w_avg_new;
  logic                   w_full;
  logic                   w_alarm;

  // Reset and soft clear are equivalent; either one drops a same-cycle sample.
  assign w_clr      = reset_reset | clear;
  assign w_accept   = data_valid & ~w_clr;
  assign w_old      = r_buf[r_wptr];
  // The evicted entry is always part of the sum, so the subtraction never wraps.
  assign w_sum_next = r_sum - {{LOG2_DEPTH{1'b0}}, w_old}
                            + {{LOG2_DEPTH{1'b0}}, data_in};
  assign w_avg_new  = r_sum[SUM_W-1:LOG2_DEPTH];
  assign w_full     = (r_fill == FILL_FULL);

  // Sample window storage: overwrite the oldest entry on each accepted sample.
  always_ff @(posedge clk_clk) begin
    if (w_clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else if (data_valid) begin
      r_buf[r_wptr] <= data_in;
    end
  end

  // E0: running sum, write pointer and saturating fill count.
  always_ff @(posedge clk_clk) begin
    if (w_clr) begin
      r_sum  <= '0;
      r_wptr <= '0;
      r_fill <= '0;
    end else if (data_valid) begin
      r_sum  <= w_sum_next;
      r_wptr <= r_wptr + 1'b1;
      if (!w_full) begin
        r_fill <= r_fill + 1'b1;
      end
    end
  end

  // E1: publish the average one edge after the sum settles; a clear in
  // between cancels the pending pulse.
  always_ff @(posedge clk_clk) begin
    if (w_clr) begin
      r_pend      <= 1'b0;
      r_avg       <= '0;
      r_avg_valid <= 1'b0;
      r_primed    <= 1'b0;
    end else begin
      r_pend      <= w_accept;
      r_avg_valid <= r_pend;
      if (r_pend) begin
        r_avg <= w_avg_new;
        if (w_full) begin
          r_primed <= 1'b1;
        end
      end
    end
  end

  anemo_hyst_cmp u_hyst (
    .i_clk    (clk_clk),
    .i_rst    (w_clr),
    .i_update (r_pend),
    .i_value  (w_avg_new),
    .i_on     (SAMPLE_W'(ALARM_ON)),
    .i_off    (SAMPLE_W'(ALARM_OFF)),
    .o_alarm  (w_alarm)
  );

`ifdef ANEMO_PEAK_HOLD_EN
  sample_t r_peak;

  // Peak hold of raw accepted samples; ties leave the stored peak alone.
  always_ff @(posedge clk_clk) begin
    if (w_clr) begin
      r_peak <= '0;
    end else if (data_valid && (data_in > r_peak)) begin
      r_peak <= data_in;
    end
  end

  assign peak_out = r_peak;
`else
  assign peak_out = '0;
`endif

  assign avg_out    = r_avg;
  assign avg_valid  = r_avg_valid;
  assign avg_primed = r_primed;
  assign alarm      = w_alarm;

endmodule

// File: tb/tb_anemo_wind_averager.sv
// Directed bench for anemo_wind_averager with a 4-entry window.
module tb_anemo_wind_averager;

  logic       clk_clk = 1'b0;
  logic       reset_reset = 1'b1;
  logic       clear = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic       data_valid = 1'b0;
  logic [7:0] avg_out;
  logic       avg_valid;
  logic       avg_primed;
  logic       alarm;
  logic [7:0] peak_out;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic [7:0] avg;
    logic       primed;
    logic       alarm;
  } rec_t;

  rec_t q[$];

  anemo_wind_averager #(
    .LOG2_DEPTH (2),
    .ALARM_ON   (200),
    .ALARM_OFF  (180)
  ) dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .clear       (clear),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .avg_out     (avg_out),
    .avg_valid   (avg_valid),
    .avg_primed  (avg_primed),
    .alarm       (alarm),
    .peak_out    (peak_out)
  );

  always #5 clk_clk = ~clk_clk;

  always @(posedge clk_clk) cyc <= cyc + 1;

  // Capture every avg_valid cycle with its cycle index.
  always @(negedge clk_clk) begin
    if (avg_valid === 1'b1) begin
      rec_t r;
      r.cyc    = cyc;
      r.avg    = avg_out;
      r.primed = avg_primed;
      r.alarm  = alarm;
      q.push_back(r);
    end
  end

  task automatic step();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send(input logic [7:0] d, output int c);
    data_valid = 1'b1;
    data_in    = d;
    c          = cyc;
    step();
    data_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_reset = 1'b1;
    idle(3);
    reset_reset = 1'b0;
    step();
    n_cmp++; if (avg_out !== 8'd0)    begin n_err++; $display("FAIL reset_avg: got %0d expected 0", avg_out); end
    n_cmp++; if (avg_valid !== 1'b0)  begin n_err++; $display("FAIL reset_valid: got %b expected 0", avg_valid); end
    n_cmp++; if (avg_primed !== 1'b0) begin n_err++; $display("FAIL reset_primed: got %b expected 0", avg_primed); end
    n_cmp++; if (alarm !== 1'b0)      begin n_err++; $display("FAIL reset_alarm: got %b expected 0", alarm); end
    n_cmp++; if (peak_out !== 8'd0)   begin n_err++; $display("FAIL reset_peak: got %0d expected 0", peak_out); end
  endtask

  task automatic test_fill();
    int         sc[4];
    logic [7:0] ea[4] = '{8'd25, 8'd50, 8'd75, 8'd100};
    logic       ep[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    q.delete();
    for (int i = 0; i < 4; i++) send(8'd100, sc[i]);
    idle(3);
    n_cmp++; if (q.size() !== 4) begin n_err++; $display("FAIL fill_count: got %0d expected 4", q.size()); end
    for (int i = 0; i < 4 && i < q.size(); i++) begin
      n_cmp++; if (q[i].avg !== ea[i])     begin n_err++; $display("FAIL fill_avg[%0d]: got %0d expected %0d", i, q[i].avg, ea[i]); end
      n_cmp++; if (q[i].cyc !== sc[i] + 2) begin n_err++; $display("FAIL fill_lat[%0d]: got cycle %0d expected %0d", i, q[i].cyc, sc[i] + 2); end
      n_cmp++; if (q[i].primed !== ep[i])  begin n_err++; $display("FAIL fill_primed[%0d]: got %b expected %b", i, q[i].primed, ep[i]); end
      n_cmp++; if (q[i].alarm !== 1'b0)    begin n_err++; $display("FAIL fill_alarm[%0d]: got %b expected 0", i, q[i].alarm); end
    end
  endtask

  task automatic test_alarm_rise();
    int         sc[4];
    logic [7:0] ea[4] = '{8'd125, 8'd150, 8'd175, 8'd200};
    logic       el[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    q.delete();
    for (int i = 0; i < 4; i++) send(8'd200, sc[i]);
    idle(3);
    n_cmp++; if (q.size() !== 4) begin n_err++; $display("FAIL rise_count: got %0d expected 4", q.size()); end
    for (int i = 0; i < 4 && i < q.size(); i++) begin
      n_cmp++; if (q[i].avg !== ea[i])     begin n_err++; $display("FAIL rise_avg[%0d]: got %0d expected %0d", i, q[i].avg, ea[i]); end
      n_cmp++; if (q[i].alarm !== el[i])   begin n_err++; $display("FAIL rise_alarm[%0d]: got %b expected %b", i, q[i].alarm, el[i]); end
      n_cmp++; if (q[i].cyc !== sc[i] + 2) begin n_err++; $display("FAIL rise_lat[%0d]: got cycle %0d expected %0d", i, q[i].cyc, sc[i] + 2); end
    end
  endtask

  task automatic test_hyst_fall();
    int         sc[3];
    logic [7:0] ea[3] = '{8'd190, 8'd180, 8'd170};
    logic       el[3] = '{1'b1, 1'b1, 1'b0};
    q.delete();
    for (int i = 0; i < 3; i++) send(8'd160, sc[i]);
    idle(3);
    n_cmp++; if (q.size() !== 3) begin n_err++; $display("FAIL fall_count: got %0d expected 3", q.size()); end
    for (int i = 0; i < 3 && i < q.size(); i++) begin
      n_cmp++; if (q[i].avg !== ea[i])    begin n_err++; $display("FAIL fall_avg[%0d]: got %0d expected %0d", i, q[i].avg, ea[i]); end
      n_cmp++; if (q[i].alarm !== el[i])  begin n_err++; $display("FAIL fall_alarm[%0d]: got %b expected %b", i, q[i].alarm, el[i]); end
      n_cmp++; if (q[i].primed !== 1'b1)  begin n_err++; $display("FAIL fall_primed[%0d]: got %b expected 1", i, q[i].primed); end
    end
  endtask

  // Window holds 160,160,160,200 (oldest at slot 3); sum 680.
  task automatic test_spacing();
    int         sc[3];
    logic [7:0] ea[3] = '{8'd125, 8'd90, 8'd55};
    q.delete();
    for (int i = 0; i < 3; i++) begin
      send(8'd20, sc[i]);
      idle(4);
    end
    idle(2);
    n_cmp++; if (q.size() !== 3) begin n_err++; $display("FAIL space_count: got %0d expected 3", q.size()); end
    for (int i = 0; i < 3 && i < q.size(); i++) begin
      n_cmp++; if (q[i].avg !== ea[i])     begin n_err++; $display("FAIL space_avg[%0d]: got %0d expected %0d", i, q[i].avg, ea[i]); end
      n_cmp++; if (q[i].cyc !== sc[i] + 2) begin n_err++; $display("FAIL space_lat[%0d]: got cycle %0d expected %0d", i, q[i].cyc, sc[i] + 2); end
    end
  endtask

  task automatic test_clear();
    int c;
    q.delete();
    clear      = 1'b1;
    data_valid = 1'b1;
    data_in    = 8'd255;
    step();
    clear      = 1'b0;
    data_valid = 1'b0;
    n_cmp++; if (avg_out !== 8'd0)    begin n_err++; $display("FAIL clr_avg: got %0d expected 0", avg_out); end
    n_cmp++; if (avg_valid !== 1'b0)  begin n_err++; $display("FAIL clr_valid: got %b expected 0", avg_valid); end
    n_cmp++; if (avg_primed !== 1'b0) begin n_err++; $display("FAIL clr_primed: got %b expected 0", avg_primed); end
    n_cmp++; if (alarm !== 1'b0)      begin n_err++; $display("FAIL clr_alarm: got %b expected 0", alarm); end
    n_cmp++; if (peak_out !== 8'd0)   begin n_err++; $display("FAIL clr_peak: got %0d expected 0", peak_out); end
    idle(3);
    n_cmp++; if (q.size() !== 0) begin n_err++; $display("FAIL clr_dropped: got %0d pulses expected 0", q.size()); end
    send(8'd40, c);
    idle(3);
    n_cmp++; if (q.size() !== 1) begin n_err++; $display("FAIL clr_next_count: got %0d expected 1", q.size()); end
    if (q.size() > 0) begin
      n_cmp++; if (q[0].avg !== 8'd10)    begin n_err++; $display("FAIL clr_next_avg: got %0d expected 10", q[0].avg); end
      n_cmp++; if (q[0].primed !== 1'b0)  begin n_err++; $display("FAIL clr_next_primed: got %b expected 0", q[0].primed); end
      n_cmp++; if (q[0].cyc !== c + 2)    begin n_err++; $display("FAIL clr_next_lat: got cycle %0d expected %0d", q[0].cyc, c + 2); end
    end
  endtask

  task automatic test_pending_cancel();
    int c;
    q.delete();
    send(8'd80, c);
    clear = 1'b1;
    step();
    clear = 1'b0;
    idle(3);
    n_cmp++; if (q.size() !== 0)    begin n_err++; $display("FAIL cancel_count: got %0d expected 0", q.size()); end
    n_cmp++; if (avg_out !== 8'd0)  begin n_err++; $display("FAIL cancel_avg: got %0d expected 0", avg_out); end
  endtask

  task automatic test_peak();
    int         c;
    logic [7:0] din[3] = '{8'd30, 8'd90, 8'd50};
`ifdef ANEMO_PEAK_HOLD_EN
    logic [7:0] ep[3] = '{8'd30, 8'd90, 8'd90};
`else
    logic [7:0] ep[3] = '{8'd0, 8'd0, 8'd0};
`endif
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(din[i], c);
      n_cmp++; if (peak_out !== ep[i]) begin n_err++; $display("FAIL peak[%0d]: got %0d expected %0d", i, peak_out, ep[i]); end
      idle(2);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_cmp++; if (peak_out !== 8'd0) begin n_err++; $display("FAIL peak_clr: got %0d expected 0", peak_out); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_alarm_rise();
    test_hyst_fall();
    test_spacing();
    test_clear();
    test_pending_cancel();
    test_peak();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
